rom_access_arbiter: RTL and testbench

//  Shares one 8Kx16 synchronous ROM (1-cycle registered read) between two requesters.

---
 rtl/rom_access_arbiter.sv | 90 +++++++++
 tb/tb_rom_access_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous ROM between a strict-priority video fetch port and a
// handshaked host read port; video never stalls, host fills idle ROM cycles.
module rom_access_arbiter #(
  parameter int AW       = 13,
  parameter int DW       = 16,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 255,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_valid,
  output logic [DW-1:0] vid_data,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  output logic          host_ready,
  output logic          host_valid,
  output logic [DW-1:0] host_data,
  output logic          host_starved,
  input  logic          host_starve_clr,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ISSUED = 2'd2;

  logic [1:0]             state;
  logic [AW-1:0]          haddr_q;
  logic [CW-1:0]          wcnt;
  // Per stage {vid_tag, host_tag}; the last stage is the registered valid pair.
  logic [ROM_LAT:0][1:0]  vld_pipe;
  logic                   accept;
  logic                   grant;
  logic                   starve_set;

  assign host_ready = (state == S_IDLE) && reset_n;
  assign accept     = host_req && host_ready;
  assign grant      = (state == S_WAIT) && !vid_req;
  assign rom_addr   = grant ? haddr_q : vid_addr;
  assign starve_set = (state == S_WAIT) && (wcnt == CW'(MAX_WAIT - 1));
  assign vid_valid  = vld_pipe[ROM_LAT][1];
  assign host_valid = vld_pipe[ROM_LAT][0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      haddr_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state   <= S_WAIT;
          haddr_q <= host_addr;
        end
        S_WAIT:   if (grant) state <= S_ISSUED;
        // Leave on the edge that raises host_valid so ready overlaps valid.
        S_ISSUED: if (vld_pipe[ROM_LAT-1][0]) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt         <= '0;
      host_starved <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        if (grant)                        wcnt <= '0;
        else if (wcnt != CW'(MAX_WAIT))   wcnt <= wcnt + CW'(1);
      end
      if (starve_set)           host_starved <= 1'b1;
      else if (host_starve_clr) host_starved <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      vid_data  <= '0;
      host_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ROM_LAT-1:0], {vid_req, grant}};
      if (vld_pipe[ROM_LAT-1][1]) vid_data  <= rom_dout;
      if (vld_pipe[ROM_LAT-1][0]) host_data <= rom_dout;
    end
  end
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Random + directed stimulus on two arbiters (ROM_LAT 1 and 3) sharing inputs,
// each checked against an event-time model of the read latencies.
module tb_rom_access_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        vid_req, host_req, host_starve_clr;
  logic [12:0] vid_addr, host_addr;
  int          checks = 0;
  int          errors = 0;

  typedef struct { int due; logic [15:0] d; } vent_t;

  always #5 clk = ~clk;

  function automatic logic [15:0] romf(input logic [12:0] a);
    logic [15:0] t;
    t = {3'b000, a} * 16'd40503;
    return t ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int LAT = (k == 0) ? 1 : 3;
    localparam int MW  = 8;
    logic        vv, hv, hr, hs;
    logic [15:0] vd, hd, rd;
    logic [12:0] ra;
    logic [12:0] ap [LAT];

    rom_access_arbiter #(.AW(13), .DW(16), .ROM_LAT(LAT), .MAX_WAIT(MW), .CW(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vv), .vid_data(vd),
      .host_req(host_req), .host_addr(host_addr), .host_ready(hr),
      .host_valid(hv), .host_data(hd), .host_starved(hs),
      .host_starve_clr(host_starve_clr), .rom_addr(ra), .rom_dout(rd)
    );

    // ROM: address in cycle t, data visible in cycle t+LAT.
    always @(posedge clk) begin
      ap[0] <= ra;
      for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
    end
    assign rd = romf(ap[LAT-1]);

    string       pfx = (LAT == 1) ? "L1" : "L3";
    int          cyc = 0;
    bit          busy = 0, waiting = 0, starved = 0, ev, eh, set;
    int          wcnt = 0, hdue = 0;
    logic [12:0] haddr = '0;
    logic [15:0] vdx = '0, hdx = '0;
    vent_t       vq[$];

    always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
        busy = 0; waiting = 0; starved = 0; wcnt = 0; vdx = '0; hdx = '0;
        vq.delete();
        chk({pfx, " rst vid_valid"},  32'(vv), 32'(0));
        chk({pfx, " rst host_valid"}, 32'(hv), 32'(0));
        chk({pfx, " rst host_ready"}, 32'(hr), 32'(0));
        chk({pfx, " rst starved"},    32'(hs), 32'(0));
        chk({pfx, " rst vid_data"},   32'(vd), 32'(0));
        chk({pfx, " rst host_data"},  32'(hd), 32'(0));
      end else begin
        ev = 0;
        if (vq.size() > 0 && vq[0].due == cyc) begin
          ev  = 1;
          vdx = vq[0].d;
          void'(vq.pop_front());
        end
        eh = busy && !waiting && (hdue == cyc);
        if (eh) begin
          hdx  = romf(haddr);
          busy = 0;
        end
        chk({pfx, " vid_valid"},    32'(vv), 32'(ev));
        chk({pfx, " vid_data"},     32'(vd), 32'(vdx));
        chk({pfx, " host_valid"},   32'(hv), 32'(eh));
        chk({pfx, " host_data"},    32'(hd), 32'(hdx));
        chk({pfx, " host_ready"},   32'(hr), 32'(!busy));
        chk({pfx, " host_starved"}, 32'(hs), 32'(starved));
        chk({pfx, " rom_addr"},     32'(ra), 32'((!vid_req && waiting) ? haddr : vid_addr));
        // State advance for the coming edge.
        if (vid_req) vq.push_back('{cyc + LAT + 1, romf(vid_addr)});
        set = 0;
        if (waiting) begin
          wcnt++;
          if (wcnt == MW) set = 1;
          if (!vid_req) begin
            waiting = 0;
            hdue    = cyc + LAT + 1;
            wcnt    = 0;
          end
        end
        if (set) starved = 1;
        else if (host_starve_clr) starved = 0;
        if (host_req && !busy) begin
          busy = 1; waiting = 1; haddr = host_addr; wcnt = 0;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [12:0] va, input logic h,
                      input logic [12:0] ha, input logic c);
    vid_req = v; vid_addr = va; host_req = h; host_addr = ha; host_starve_clr = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] raddr();
    logic [12:0] a;
    case ($urandom_range(0, 7))
      0:       a = 13'h1FFF;
      1:       a = 13'h0000;
      default: a = 13'($urandom);
    endcase
    return a;
  endfunction

  initial begin
    reset_n = 1'b0;
    vid_req = 0; vid_addr = '0; host_req = 0; host_addr = '0; host_starve_clr = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    // Video only, consecutive addresses.
    for (int i = 0; i < 4; i++) step(1, 13'(i), 0, '0, 0);
    repeat (6) step(0, '0, 0, '0, 0);
    // Host only at the top address.
    step(0, '0, 1, 13'h1FFF, 0);
    repeat (7) step(0, '0, 0, '0, 0);
    // Host accepted during a 10-cycle video burst.
    step(1, 13'h0A00, 1, 13'h0100, 0);
    for (int i = 1; i < 10; i++) step(1, 13'(13'h0A00 + i), 0, '0, 0);
    repeat (8) step(0, '0, 0, '0, 0);
    // Starvation under a 20-cycle burst, cleared mid-burst after it set.
    step(1, 13'h0200, 1, 13'h0333, 0);
    for (int i = 1; i < 20; i++) step(1, 13'(13'h0200 + i), 0, '0, (i == 14));
    repeat (8) step(0, '0, 0, '0, 0);
    // Back-to-back host reads with host_req held high.
    for (int i = 0; i < 20; i++) step(0, '0, 1, 13'(13'h0400 + i), 0);
    repeat (8) step(0, '0, 0, '0, 0);
    // Reset one cycle after a host grant.
    step(0, '0, 1, 13'h0055, 0);
    step(0, '0, 0, '0, 0);
    step(0, '0, 0, '0, 0);
    reset_n = 1'b0;
    step(1, 13'h0066, 1, 13'h0077, 0);
    reset_n = 1'b1;
    repeat (8) step(0, '0, 0, '0, 0);
    // Random phases of varying video density.
    for (int p = 0; p < 15; p++) begin
      int vp;
      vp = (p % 3 == 0) ? 10 : (p % 3 == 1) ? 50 : 92;
      for (int i = 0; i < 100; i++) begin
        reset_n = ($urandom_range(0, 199) != 0);
        step($urandom_range(0, 99) < vp, raddr(), $urandom_range(0, 1) == 1, raddr(),
             $urandom_range(0, 29) == 0);
      end
    end
    reset_n = 1'b1;
    repeat (10) step(0, '0, 0, '0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
